// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the sequential float multiplier.
// State encoding, IEEE-754 field widths and the unpacked-float bundle.
package fpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_e;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   // exp is a 10-bit two's-complement working exponent
   typedef struct packed {
      logic              sign;
      logic [EXP_W+1:0]  exp;
      logic [FRAC_W-1:0] mant;
   } fp_unp_t;

endpackage

// File: rtl/mant_mul_serial.sv
// 24x24 shift-add mantissa multiplier, BITS_PER_CYCLE bits per step.
// start loads operands; done is high during the final accumulate step.
module mant_mul_serial
   import fpu_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [FRAC_W:0]     mcand,
   input  logic [FRAC_W:0]     mplier,
   output logic                done,
   output logic [2*FRAC_W+1:0] product
);

   localparam int MW = FRAC_W + 1;
   localparam int PW = 2 * MW;
   localparam int K  = MW / BITS_PER_CYCLE;

   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] mc_q, mc_d;
   logic [MW-1:0] mp_q, mp_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [PW-1:0] pp;

   // one partial product per step, weight tracked by shifting mcand
   always_comb begin
      acc_d  = acc_q;
      mc_d   = mc_q;
      mp_d   = mp_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      pp     = mc_q * PW'(mp_q[BITS_PER_CYCLE-1:0]);
      done   = busy_q && (cnt_q == 5'(K - 1));
      if (start) begin
         acc_d  = '0;
         mc_d   = {{MW{1'b0}}, mcand};
         mp_d   = mplier;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d = acc_q + pp;
         mc_d  = mc_q << BITS_PER_CYCLE;
         mp_d  = mp_q >> BITS_PER_CYCLE;
         cnt_d = cnt_q + 5'd1;
         if (done) busy_d = 1'b0;
      end
   end

   // datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         mc_q   <= '0;
         mp_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         mc_q   <= mc_d;
         mp_q   <= mp_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign product = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier: FSM, specials, normalize, round.
// Define FP_MUL_RNE_EN for round-to-nearest-even; default truncates.
module fp_mul_seq
   import fpu_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_ovf,
   output logic        flag_unf,
   output logic        flag_inv
);

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [EXP_W-1:0]  ea_q, ea_d;
   logic [EXP_W-1:0]  eb_q, eb_d;
   fp_unp_t           nrm_q, nrm_d;
   logic              guard_q, guard_d;
   logic              sticky_q, sticky_d;
   logic [31:0]       result_q, result_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              inv_q, inv_d;

   logic              mul_start;
   logic              mul_done;
   logic [47:0]       prod;

   logic              a_zero, a_inf, a_nan;
   logic              b_zero, b_inf, b_nan;
   logic              is_inv, is_inf, is_zero;
   logic              sgn_in;
   logic              rnd_inc;
   logic [FRAC_W:0]   rnd_sum;
   logic signed [9:0] e_base, e_rnd;

   mant_mul_serial #(
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mul_start),
      .mcand  ({1'b1, a[FRAC_W-1:0]}),
      .mplier ({1'b1, b[FRAC_W-1:0]}),
      .done   (mul_done),
      .product(prod)
   );

   // operand class decode; denormals count as zero
   always_comb begin
      a_zero  = (a[30:23] == '0);
      b_zero  = (b[30:23] == '0);
      a_inf   = (a[30:23] == '1) && (a[22:0] == '0);
      b_inf   = (b[30:23] == '1) && (b[22:0] == '0);
      a_nan   = (a[30:23] == '1) && (a[22:0] != '0);
      b_nan   = (b[30:23] == '1) && (b[22:0] != '0);
      sgn_in  = a[31] ^ b[31];
      is_inv  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
      is_inf  = (a_inf | b_inf) & ~is_inv;
      is_zero = (a_zero | b_zero) & ~is_inv;
   end

`ifdef FP_MUL_RNE_EN
   assign rnd_inc = guard_q & (sticky_q | nrm_q.mant[0]);
`else
   logic unused_gs;
   assign unused_gs = guard_q ^ sticky_q;
   assign rnd_inc   = 1'b0;
`endif

   // next-state, normalize and round
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      ea_d      = ea_q;
      eb_d      = eb_q;
      nrm_d     = nrm_q;
      guard_d   = guard_q;
      sticky_d  = sticky_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      inv_d     = inv_q;
      mul_start = 1'b0;
      e_base    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q})
                  - 10'(EXP_BIAS);
      rnd_sum   = {1'b0, nrm_q.mant} + {{FRAC_W{1'b0}}, rnd_inc};
      e_rnd     = $signed(nrm_q.exp) + $signed({9'd0, rnd_sum[FRAC_W]});
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = sgn_in;
               ea_d   = a[30:23];
               eb_d   = b[30:23];
               if (is_inv) begin
                  result_d = QNAN;
                  inv_d    = 1'b1;
                  state_d  = S_DONE;
               end else if (is_inf) begin
                  result_d = {sgn_in, POS_INF[30:0]};
                  state_d  = S_DONE;
               end else if (is_zero) begin
                  result_d = {sgn_in, 31'd0};
                  state_d  = S_DONE;
               end else begin
                  mul_start = 1'b1;
                  state_d   = S_MUL;
               end
            end
         end
         S_MUL: begin
            if (mul_done) state_d = S_NORM;
         end
         S_NORM: begin
            nrm_d.sign = sign_q;
            if (prod[47]) begin
               nrm_d.exp  = 10'(e_base + 10'sd1);
               nrm_d.mant = prod[46:24];
               guard_d    = prod[23];
               sticky_d   = |prod[22:0];
            end else begin
               nrm_d.exp  = 10'(e_base);
               nrm_d.mant = prod[45:23];
               guard_d    = prod[22];
               sticky_d   = |prod[21:0];
            end
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (e_rnd >= 10'sd255) begin
               result_d = {nrm_q.sign, POS_INF[30:0]};
               ovf_d    = 1'b1;
            end else if (e_rnd <= 10'sd0) begin
               result_d = {nrm_q.sign, 31'd0};
               unf_d    = 1'b1;
            end else begin
               result_d = {nrm_q.sign, e_rnd[7:0],
                           rnd_sum[FRAC_W-1:0]};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               inv_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         nrm_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         nrm_q    <= nrm_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inv_q    <= inv_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flag_ovf  = ovf_q;
   assign flag_unf  = unf_q;
   assign flag_inv  = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq.
// Covers BITS_PER_CYCLE=1 and 8, specials, handshake and reset.
module tb_fp_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] a, b;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        flag_ovf, flag_unf, flag_inv;

   logic        in_valid8, in_ready8;
   logic [31:0] a8, b8;
   logic        out_valid8, out_ready8;
   logic [31:0] result8;
   logic        ovf8, unf8, inv8;

   int total = 0;
   int bad   = 0;

`ifdef FP_MUL_RNE_EN
   localparam logic [31:0] EXP_ROUND = 32'h4040_0002;
`else
   localparam logic [31:0] EXP_ROUND = 32'h4040_0001;
`endif

   always #5 clk = ~clk;

   fp_mul_seq #(.BITS_PER_CYCLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
   );

   fp_mul_seq #(.BITS_PER_CYCLE(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8),
      .flag_ovf(ovf8), .flag_unf(unf8), .flag_inv(inv8)
   );

   // stimulus only: one operation, returns result, flags, latency
   task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] r, output logic [2:0] fl,
                        output int cyc);
      a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid && cyc < 200);
      r  = result;
      fl = {flag_ovf, flag_unf, flag_inv};
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: rdy=%b vld=%b need 1 0",
                  in_ready, out_valid);
      end
      total++;
      if (result !== 32'h0 ||
          {flag_ovf, flag_unf, flag_inv} !== 3'b000) begin
         bad++;
         $display("FAIL reset_out: res=%h fl=%b need 0 000", result,
                  {flag_ovf, flag_unf, flag_inv});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [31:0] r; logic [2:0] fl; int c;
      do_op(32'h3F80_0000, 32'h4000_0000, r, fl, c);
      total++;
      if (r !== 32'h4000_0000 || fl !== 3'b000) begin
         bad++;
         $display("FAIL one_x_two: res=%h fl=%b need 40000000 000", r, fl);
      end
      total++;
      if (c !== 26) begin
         bad++;
         $display("FAIL lat_k1: got %0d need 26", c);
      end
      do_op(32'h3B80_8081, 32'h437F_0000, r, fl, c);
      total++;
      if (r !== 32'h3F80_0000 || fl !== 3'b000 || c !== 26) begin
         bad++;
         $display("FAIL recip255: res=%h fl=%b c=%0d need 3f800000 000 26",
                  r, fl, c);
      end
   endtask

   task automatic test_round();
      logic [31:0] r; logic [2:0] fl; int c;
      do_op(32'h3F80_0001, 32'h4040_0000, r, fl, c);
      total++;
      if (r !== EXP_ROUND || fl !== 3'b000 || c !== 26) begin
         bad++;
         $display("FAIL round: res=%h fl=%b c=%0d need %h 000 26",
                  r, fl, c, EXP_ROUND);
      end
      do_op(32'hBF80_0000, 32'h4040_0000, r, fl, c);
      total++;
      if (r !== 32'hC040_0000 || fl !== 3'b000) begin
         bad++;
         $display("FAIL neg_sign: res=%h fl=%b need c0400000 000", r, fl);
      end
   endtask

   task automatic test_range();
      logic [31:0] r; logic [2:0] fl; int c;
      do_op(32'h7F00_0000, 32'h4000_0000, r, fl, c);
      total++;
      if (r !== 32'h7F80_0000 || fl !== 3'b100 || c !== 26) begin
         bad++;
         $display("FAIL ovf: res=%h fl=%b c=%0d need 7f800000 100 26",
                  r, fl, c);
      end
      do_op(32'h0080_0000, 32'h0080_0000, r, fl, c);
      total++;
      if (r !== 32'h0000_0000 || fl !== 3'b010 || c !== 26) begin
         bad++;
         $display("FAIL unf: res=%h fl=%b c=%0d need 00000000 010 26",
                  r, fl, c);
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [5] = '{32'h0000_0000, 32'h8000_0000,
                              32'h7F80_0000, 32'h7FC0_1234,
                              32'hFF80_0000};
      logic [31:0] vb [5] = '{32'h7F80_0000, 32'h3F80_0000,
                              32'h4000_0000, 32'h3F80_0000,
                              32'h4000_0000};
      logic [31:0] vr [5] = '{32'h7FC0_0000, 32'h8000_0000,
                              32'h7F80_0000, 32'h7FC0_0000,
                              32'hFF80_0000};
      logic [2:0]  vf [5] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
      logic [31:0] r; logic [2:0] fl; int c;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], r, fl, c);
         total++;
         if (r !== vr[i] || fl !== vf[i] || c !== 1) begin
            bad++;
            $display("FAIL special%0d: res=%h fl=%b c=%0d need %h %b 1",
                     i, r, fl, c, vr[i], vf[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] held;
      int c;
      int errs;
      a = 32'h3F80_0000; b = 32'h4040_0000;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 a = 32'h4000_0000;
      c = 0;
      while (!out_valid && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      held = result;
      total++;
      if (held !== 32'h4040_0000) begin
         bad++;
         $display("FAIL hold_res: got %h need 40400000", held);
      end
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (result !== 32'h4040_0000 || in_ready !== 1'b0 ||
             out_valid !== 1'b1) errs++;
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL hold_stable: %0d bad cycles need 0", errs);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_release: vld=%b rdy=%b need 0 1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic [2:0] fl; int c;
      a = 32'h3F80_0000; b = 32'h4000_0000;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          result !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset: vld=%b rdy=%b res=%h need 0 1 0",
                  out_valid, in_ready, result);
      end
      rst_n = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      do_op(32'h3F80_0001, 32'h4040_0000, r, fl, c);
      total++;
      if (r !== EXP_ROUND || fl !== 3'b000 || c !== 26) begin
         bad++;
         $display("FAIL after_reset: res=%h fl=%b c=%0d need %h 000 26",
                  r, fl, c, EXP_ROUND);
      end
   endtask

   task automatic test_bpc8();
      int c;
      logic [31:0] r;
      a8 = 32'h3F80_0000; b8 = 32'h4000_0000;
      in_valid8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!out_valid8 && c < 200);
      r = result8;
      total++;
      if (r !== 32'h4000_0000 || c !== 5 ||
          {ovf8, unf8, inv8} !== 3'b000) begin
         bad++;
         $display("FAIL bpc8: res=%h c=%0d need 40000000 5", r, c);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      a8 = 32'h3F80_0001; b8 = 32'h4040_0000;
      in_valid8 = 1'b1;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!out_valid8 && c < 200);
      total++;
      if (result8 !== EXP_ROUND || c !== 5) begin
         bad++;
         $display("FAIL bpc8_round: res=%h c=%0d need %h 5",
                  result8, c, EXP_ROUND);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
      rst_n = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_round();
      test_range();
      test_specials();
      test_hold();
      test_reset_mid();
      test_bpc8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
